// File: rtl/load_arbiter_ctrl_if.sv
// -----------------------------------------------------------------------------
// load_arbiter_ctrl_if
// Bundle of the request/data/grant signals between the two producer blocks and
// the shared load register arbiter.
//
// Handshake (req/gnt/ack): a requester raises req[k] with d<k>/m[k] valid and
// keeps it high until it sees ack[k]. gnt[k] is high from the grant edge
// through the ack cycle. ack[k] is a single-cycle completion pulse. Data and
// mode are taken only at the grant edge. Dropping req after the grant does
// not cancel the load.
//
// Signals:
//   req   [1:0]   request per requester
//   d0    [N-1:0] load data from requester 0
//   d1    [N-1:0] load data from requester 1
//   m     [1:0]   mode per requester (0 parallel, 1 bit-serial)
//   gnt   [1:0]   one-hot grant
//   ack   [1:0]   one-cycle completion pulse
//   busy          a load is granted
//   idx   [IW-1:0] serial bit index
//   q     [N-1:0] shared register contents
// Modports: master = producer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface load_arbiter_ctrl_if #(
   parameter int N  = 8,
   parameter int IW = 3
);
   logic [1:0]    req;
   logic [N-1:0]  d0;
   logic [N-1:0]  d1;
   logic [1:0]    m;
   logic [1:0]    gnt;
   logic [1:0]    ack;
   logic          busy;
   logic [IW-1:0] idx;
   logic [N-1:0]  q;

   modport master (
      output req, d0, d1, m,
      input  gnt, ack, busy, idx, q
   );

   modport slave (
      input  req, d0, d1, m,
      output gnt, ack, busy, idx, q
   );
endinterface

// File: rtl/load_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// load_arbiter_ctrl
// Round-robin arbiter for two requesters sharing one N-bit load register q.
// The winner's data and mode are captured at the grant edge, then loaded
// either in one cycle (parallel) or one bit per cycle LSB first (bit-serial).
// A one-cycle DONE state pulses ack to the winner, after which the priority
// pointer moves to the other requester.
//
// Ports:
//   c          clock, all state changes on posedge
//   r          synchronous active-high reset (aborts any load, clears q)
//   bus        load_arbiter_ctrl_if slave modport (req/d0/d1/m in,
//              gnt/ack/busy/idx/q out)
//   dbg_state  current FSM state (IDLE=0, LOAD=1, DONE=2)
// -----------------------------------------------------------------------------
module load_arbiter_ctrl #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic                c,
   input  logic                r,
   load_arbiter_ctrl_if.slave  bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic          p;        // priority pointer: requester favoured on a tie
   logic          win;      // requester currently being served
   logic          win_nx;   // arbitration result in IDLE
   logic          hmode;    // captured mode of the winner
   logic [N-1:0]  hold;     // captured data of the winner
   logic [N-1:0]  q_r;
   logic [IW-1:0] idx_r;
   logic          grant;
   logic          last_bit;
   logic [1:0]    win_oh;
   logic [1:0]    gnt_c;
   logic [1:0]    ack_c;
   logic          busy_c;

   // FSM next state and decoded outputs
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      gnt_c    = 2'b00;
      ack_c    = 2'b00;
      busy_c   = 1'b0;
      // Tie goes to the pointer; otherwise the single active request wins.
      win_nx   = (bus.req == 2'b11) ? p : bus.req[1];
      last_bit = (idx_r == IW'(N - 1));
      win_oh   = win ? 2'b10 : 2'b01;

      case (state)
         IDLE: begin
            if (bus.req != 2'b00) begin
               grant    = 1'b1;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            gnt_c  = win_oh;
            busy_c = 1'b1;
            // Parallel finishes in one edge; serial finishes on the edge
            // that writes the top bit (so N=1 serial matches parallel).
            if (!hmode || last_bit) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            gnt_c    = win_oh;
            ack_c    = win_oh;
            busy_c   = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge c) begin
      if (r) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath: capture at grant, load q, rotate priority after completion
   always_ff @(posedge c) begin
      if (r) begin
         p     <= 1'b0;
         win   <= 1'b0;
         hmode <= 1'b0;
         hold  <= '0;
         q_r   <= '0;
         idx_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  win   <= win_nx;
                  hold  <= win_nx ? bus.d1 : bus.d0;
                  hmode <= bus.m[win_nx];
               end
            end
            LOAD: begin
               if (!hmode) begin
                  q_r <= hold;
               end else begin
                  q_r[idx_r] <= hold[idx_r];
                  idx_r      <= last_bit ? '0 : idx_r + IW'(1);
               end
            end
            DONE: begin
               p <= ~win;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.gnt   = gnt_c;
   assign bus.ack   = ack_c;
   assign bus.busy  = busy_c;
   assign bus.idx   = idx_r;
   assign bus.q     = q_r;
   assign dbg_state = state;

endmodule

// File: tb/tb_load_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_load_arbiter_ctrl
// Self-checking bench for load_arbiter_ctrl (N=8). The reference model tracks
// only the priority pointer and the register contents at transaction level;
// each transfer's expected timeline is computed from the winner, its data and
// its mode with plain masks.
// -----------------------------------------------------------------------------
module tb_load_arbiter_ctrl;

   localparam int N  = 8;
   localparam int IW = 3;

   logic       c;
   logic       r;
   logic [1:0] dbg_state;

   load_arbiter_ctrl_if #(.N(N), .IW(IW)) bus ();

   load_arbiter_ctrl #(.N(N), .IW(IW)) dut (
      .c         (c),
      .r         (r),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   int vectors    = 0;
   int miscompares = 0;

   // reference model
   logic       m_p;
   logic [7:0] m_q;

   // clock / reset
   initial c = 1'b0;
   always #5 c = ~c;

   task automatic do_reset();
      r       = 1'b1;
      bus.req = 2'b00;
      @(posedge c); #1;
      r   = 1'b0;
      m_p = 1'b0;
      m_q = 8'h00;
   endtask

   task automatic idle_cycle();
      bus.req = 2'b00;
      @(posedge c); #1;
      vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL idle_gnt: got %b want 00", bus.gnt); end
      vectors++; if (bus.q !== m_q) begin miscompares++; $display("FAIL idle_q: got %h want %h", bus.q, m_q); end
   endtask

   // One complete transfer from IDLE with req/d/m already driven.
   // drop: release req right after the grant; flip: invert d0/d1/m during LOAD.
   task automatic run_load(input bit drop, input bit flip, output bit w);
      logic [7:0] hold;
      logic [7:0] mask;
      logic       mode;
      logic [1:0] oh;
      w    = (bus.req == 2'b11) ? m_p : bus.req[1];
      hold = w ? bus.d1 : bus.d0;
      mode = bus.m[w];
      oh   = w ? 2'b10 : 2'b01;
      @(posedge c); #1;
      vectors++; if (bus.gnt !== oh) begin miscompares++; $display("FAIL grant_gnt: got %b want %b", bus.gnt, oh); end
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL grant_busy: got %b want 1", bus.busy); end
      vectors++; if (bus.ack !== 2'b00) begin miscompares++; $display("FAIL grant_ack: got %b want 00", bus.ack); end
      vectors++; if (bus.q !== m_q) begin miscompares++; $display("FAIL grant_q: got %h want %h", bus.q, m_q); end
      if (drop) bus.req = 2'b00;
      if (flip) begin
         bus.d0 = ~bus.d0;
         bus.d1 = ~bus.d1;
         bus.m  = ~bus.m;
      end
      if (!mode) begin
         @(posedge c); #1;
         m_q = hold;
         vectors++; if (bus.q !== m_q) begin miscompares++; $display("FAIL par_q: got %h want %h", bus.q, m_q); end
      end else begin
         for (int i = 0; i < N; i++) begin
            vectors++; if (bus.idx !== IW'(i)) begin miscompares++; $display("FAIL ser_idx: got %0d want %0d", bus.idx, i); end
            @(posedge c); #1;
            mask = 8'((16'd1 << (i + 1)) - 16'd1);
            m_q  = (m_q & ~mask) | (hold & mask);
            vectors++; if (bus.q !== m_q) begin miscompares++; $display("FAIL ser_q bit %0d: got %h want %h", i, bus.q, m_q); end
            if (i < N - 1) begin
               vectors++; if (bus.ack !== 2'b00) begin miscompares++; $display("FAIL ser_early_ack: got %b want 00", bus.ack); end
            end
         end
      end
      // ack cycle
      vectors++; if (bus.ack !== oh) begin miscompares++; $display("FAIL done_ack: got %b want %b", bus.ack, oh); end
      vectors++; if (bus.gnt !== oh) begin miscompares++; $display("FAIL done_gnt: got %b want %b", bus.gnt, oh); end
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL done_busy: got %b want 1", bus.busy); end
      vectors++; if (bus.idx !== '0) begin miscompares++; $display("FAIL done_idx: got %0d want 0", bus.idx); end
      @(posedge c); #1;
      m_p = ~w;
      vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL post_gnt: got %b want 00", bus.gnt); end
      vectors++; if (bus.ack !== 2'b00) begin miscompares++; $display("FAIL post_ack: got %b want 00", bus.ack); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL post_busy: got %b want 0", bus.busy); end
      vectors++; if (bus.q !== m_q) begin miscompares++; $display("FAIL post_q: got %h want %h", bus.q, m_q); end
   endtask

   task automatic test_reset();
      r       = 1'b1;
      bus.req = 2'($urandom_range(0, 3));
      bus.d0  = 8'($urandom);
      bus.d1  = 8'($urandom);
      bus.m   = 2'($urandom_range(0, 3));
      repeat (2) @(posedge c);
      #1;
      vectors++; if (bus.q !== 8'h00) begin miscompares++; $display("FAIL reset_q: got %h want 00", bus.q); end
      vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
      vectors++; if (bus.ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b want 00", bus.ack); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      vectors++; if (bus.idx !== '0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", bus.idx); end
      r   = 1'b0;
      m_p = 1'b0;
      m_q = 8'h00;
      idle_cycle();
   endtask

   task automatic test_parallel_single();
      bit w;
      do_reset();
      bus.req = 2'b01; bus.d0 = 8'hA5; bus.m = 2'b00;
      run_load(1'b0, 1'b0, w);
      vectors++; if (bus.q !== 8'hA5) begin miscompares++; $display("FAIL single_q: got %h want a5", bus.q); end
      idle_cycle();
      // pointer should now favour requester 1
      bus.req = 2'b11; bus.d0 = 8'($urandom); bus.d1 = 8'($urandom); bus.m = 2'b00;
      run_load(1'b0, 1'b0, w);
      vectors++; if (w !== 1'b1) begin miscompares++; $display("FAIL single_next_winner: got %0d want 1", w); end
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      bit w;
      do_reset();
      bus.req = 2'b11; bus.d0 = 8'h11; bus.d1 = 8'h22; bus.m = 2'b00;
      run_load(1'b0, 1'b0, w);
      vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL b2b_first: got %0d want 0", w); end
      vectors++; if (bus.q !== 8'h11) begin miscompares++; $display("FAIL b2b_q0: got %h want 11", bus.q); end
      run_load(1'b0, 1'b0, w);
      vectors++; if (w !== 1'b1) begin miscompares++; $display("FAIL b2b_second: got %0d want 1", w); end
      vectors++; if (bus.q !== 8'h22) begin miscompares++; $display("FAIL b2b_q1: got %h want 22", bus.q); end
      idle_cycle();
   endtask

   task automatic test_serial();
      bit w;
      do_reset();
      bus.req = 2'b10; bus.d1 = 8'hFF; bus.d0 = 8'($urandom); bus.m = 2'b10;
      run_load(1'b0, 1'b0, w);
      vectors++; if (bus.q !== 8'hFF) begin miscompares++; $display("FAIL serial_q: got %h want ff", bus.q); end
      idle_cycle();
   endtask

   task automatic test_abort();
      bit w;
      do_reset();
      bus.req = 2'b01; bus.d0 = 8'hFF; bus.m = 2'b01;
      repeat (4) @(posedge c);   // grant edge + bits 0..2
      #1;
      vectors++; if (bus.idx !== IW'(3)) begin miscompares++; $display("FAIL abort_idx_pre: got %0d want 3", bus.idx); end
      vectors++; if (bus.q !== 8'h07) begin miscompares++; $display("FAIL abort_q_pre: got %h want 07", bus.q); end
      r = 1'b1;
      @(posedge c); #1;
      r = 1'b0;
      bus.req = 2'b00;
      m_p = 1'b0;
      m_q = 8'h00;
      vectors++; if (bus.q !== 8'h00) begin miscompares++; $display("FAIL abort_q: got %h want 00", bus.q); end
      vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL abort_gnt: got %b want 00", bus.gnt); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      vectors++; if (bus.idx !== '0) begin miscompares++; $display("FAIL abort_idx: got %0d want 0", bus.idx); end
      vectors++; if (bus.ack !== 2'b00) begin miscompares++; $display("FAIL abort_ack: got %b want 00", bus.ack); end
      bus.req = 2'b10; bus.d1 = 8'($urandom); bus.m = 2'($urandom_range(0, 3));
      run_load(1'b0, 1'b0, w);
      vectors++; if (w !== 1'b1) begin miscompares++; $display("FAIL abort_regrant: got %0d want 1", w); end
      idle_cycle();
   endtask

   task automatic test_drop_and_change();
      bit w;
      do_reset();
      bus.req = 2'b01; bus.d0 = 8'h3C; bus.m = 2'b00;
      run_load(1'b1, 1'b1, w);   // d0 becomes C3 during LOAD
      vectors++; if (bus.q !== 8'h3C) begin miscompares++; $display("FAIL drop_q: got %h want 3c", bus.q); end
      idle_cycle();
      bus.req = 2'b01; bus.d0 = 8'($urandom); bus.m = 2'b01;
      run_load(1'b1, 1'b1, w);   // serial variant, mode flips to parallel mid-load
      idle_cycle();
   endtask

   task automatic test_round_robin();
      bit w;
      do_reset();
      bus.req = 2'b11;
      for (int t = 0; t < 4; t++) begin
         bus.d0 = 8'($urandom); bus.d1 = 8'($urandom);
         bus.m  = 2'($urandom_range(0, 3));
         run_load(1'b0, 1'b0, w);
         vectors++; if (w !== t[0]) begin miscompares++; $display("FAIL rr_order xfer %0d: got %0d want %0d", t, w, t[0]); end
      end
      idle_cycle();
   endtask

   task automatic test_random();
      bit w;
      for (int t = 0; t < 60; t++) begin
         repeat ($urandom_range(0, 2)) idle_cycle();
         bus.req = 2'($urandom_range(1, 3));
         bus.d0  = 8'($urandom);
         bus.d1  = 8'($urandom);
         bus.m   = 2'($urandom_range(0, 3));
         run_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      end
      idle_cycle();
   endtask

   initial begin
      r       = 1'b1;
      bus.req = 2'b00;
      bus.d0  = 8'h00;
      bus.d1  = 8'h00;
      bus.m   = 2'b00;
      m_p     = 1'b0;
      m_q     = 8'h00;
      test_reset();
      test_parallel_single();
      test_back_to_back();
      test_serial();
      test_abort();
      test_drop_and_change();
      test_round_robin();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
